// File: rtl/fir_band_envelope.sv
// Per-band windowed envelope detector: mean absolute level and peak magnitude
// over 2^LOG2_WIN accepted samples, published together with a one-cycle strobe.

module fir_band_env_lane #(
   parameter int LOG2_WIN = 4
) (
   input  logic       clk_slow,
   input  logic       rst,
   input  logic       accept_i,
   input  logic       close_i,
   input  logic       clear_i,
   input  logic [8:0] mag_i,
   output logic [8:0] level_o,
   output logic [8:0] peak_o
);
   localparam int AW = 9 + LOG2_WIN;

   logic [AW-1:0] acc_q, acc_d, sum;
   logic [8:0]    pk_q, pk_d, mx;
   logic [8:0]    level_q, level_d, peak_q, peak_d;

   // Accumulator is wide enough for 2^LOG2_WIN full-scale samples, so no wrap.
   assign sum = acc_q + AW'(mag_i);
   assign mx  = (mag_i > pk_q) ? mag_i : pk_q;

   always_comb begin
      acc_d   = acc_q;
      pk_d    = pk_q;
      level_d = level_q;
      peak_d  = peak_q;
      if (clear_i) begin
         acc_d = '0;
         pk_d  = '0;
      end else if (accept_i) begin
         if (close_i) begin
            level_d = sum[AW-1:LOG2_WIN];
            peak_d  = mx;
            acc_d   = '0;
            pk_d    = '0;
         end else begin
            acc_d = sum;
            pk_d  = mx;
         end
      end
   end

   always_ff @(posedge clk_slow or negedge rst) begin
      if (!rst) begin
         acc_q   <= '0;
         pk_q    <= '0;
         level_q <= '0;
         peak_q  <= '0;
      end else begin
         acc_q   <= acc_d;
         pk_q    <= pk_d;
         level_q <= level_d;
         peak_q  <= peak_d;
      end
   end

   assign level_o = level_q;
   assign peak_o  = peak_q;
endmodule

module fir_band_envelope #(
   parameter int LOG2_WIN = 4,
   parameter int NBANDS   = 4
) (
   input  logic                clk_slow,
   input  logic                rst,
   input  logic                sample_en,
   input  logic                clear,
   input  logic [9:0]          band0_in,
   input  logic [9:0]          band1_in,
   input  logic [9:0]          band2_in,
   input  logic [9:0]          band3_in,
   output logic [8:0]          level0,
   output logic [8:0]          level1,
   output logic [8:0]          level2,
   output logic [8:0]          level3,
   output logic [8:0]          peak0,
   output logic [8:0]          peak1,
   output logic [8:0]          peak2,
   output logic [8:0]          peak3,
   output logic                level_valid,
   output logic [LOG2_WIN-1:0] win_count
);
   logic [NBANDS-1:0][8:0] mag, lvl, pk;
   logic [LOG2_WIN-1:0]    cnt_q, cnt_d;
   logic                   vld_q, vld_d;
   logic                   accept, close;
   logic                   unused_sign;

   // Sign-magnitude input: the sign bit never contributes to the envelope.
   assign mag[0] = band0_in[8:0];
   assign mag[1] = band1_in[8:0];
   assign mag[2] = band2_in[8:0];
   assign mag[3] = band3_in[8:0];
   assign unused_sign = ^{band0_in[9], band1_in[9], band2_in[9], band3_in[9]};

   assign accept = sample_en & ~clear;
   assign close  = accept & (cnt_q == '1);

   always_comb begin
      cnt_d = cnt_q;
      vld_d = close;
      if (clear)
         cnt_d = '0;
      else if (accept)
         cnt_d = cnt_q + LOG2_WIN'(1);
   end

   always_ff @(posedge clk_slow or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         vld_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   for (genvar g = 0; g < NBANDS; g++) begin : g_lane
      fir_band_env_lane #(.LOG2_WIN(LOG2_WIN)) u_lane (
         .clk_slow (clk_slow),
         .rst      (rst),
         .accept_i (accept),
         .close_i  (close),
         .clear_i  (clear),
         .mag_i    (mag[g]),
         .level_o  (lvl[g]),
         .peak_o   (pk[g])
      );
   end

   assign level0      = lvl[0];
   assign level1      = lvl[1];
   assign level2      = lvl[2];
   assign level3      = lvl[3];
   assign peak0       = pk[0];
   assign peak1       = pk[1];
   assign peak2       = pk[2];
   assign peak3       = pk[3];
   assign level_valid = vld_q;
   assign win_count   = cnt_q;
endmodule

// File: tb/tb_fir_band_envelope.sv
// Directed bench for fir_band_envelope with 4-sample windows; expected
// publications are queued at the closing stimulus and popped on level_valid.

module tb_fir_band_envelope;
   localparam int L   = 2;
   localparam int WIN = 4;

   logic         clk_slow = 1'b0;
   logic         rst = 1'b0;
   logic         sample_en = 1'b0;
   logic         clear = 1'b0;
   logic [9:0]   band0_in = '0, band1_in = '0, band2_in = '0, band3_in = '0;
   logic [8:0]   level0, level1, level2, level3, peak0, peak1, peak2, peak3;
   logic         level_valid;
   logic [L-1:0] win_count;

   fir_band_envelope #(.LOG2_WIN(L), .NBANDS(4)) dut (
      .clk_slow(clk_slow), .rst(rst), .sample_en(sample_en), .clear(clear),
      .band0_in(band0_in), .band1_in(band1_in), .band2_in(band2_in), .band3_in(band3_in),
      .level0(level0), .level1(level1), .level2(level2), .level3(level3),
      .peak0(peak0), .peak1(peak1), .peak2(peak2), .peak3(peak3),
      .level_valid(level_valid), .win_count(win_count)
   );

   always #5 clk_slow = ~clk_slow;

   typedef struct packed {
      logic [35:0] lv;
      logic [35:0] pk;
   } res_t;

   res_t        exp_q[$];
   res_t        pub = '0;
   int unsigned mdl_acc[4];
   int unsigned mdl_pk[4];
   int          mdl_cnt = 0;
   int          tests = 0;
   int          failed = 0;

   wire [35:0] lv_bus = {level3, level2, level1, level0};
   wire [35:0] pk_bus = {peak3, peak2, peak1, peak0};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mdl_zero();
      for (int i = 0; i < 4; i++) begin
         mdl_acc[i] = 0;
         mdl_pk[i]  = 0;
      end
      mdl_cnt = 0;
   endtask

   // One clock: drive on the falling edge, update the model, check after the rising edge.
   task automatic step(input logic en, input logic clr,
                       input logic [9:0] x0, input logic [9:0] x1,
                       input logic [9:0] x2, input logic [9:0] x3);
      logic [9:0] xs[4];
      logic       exp_v;
      res_t       r;
      xs = '{x0, x1, x2, x3};
      @(negedge clk_slow);
      sample_en = en; clear = clr;
      band0_in = x0; band1_in = x1; band2_in = x2; band3_in = x3;
      exp_v = 1'b0;
      if (clr) begin
         mdl_zero();
      end else if (en) begin
         for (int i = 0; i < 4; i++) begin
            mdl_acc[i] += xs[i][8:0];
            if (xs[i][8:0] > mdl_pk[i]) mdl_pk[i] = xs[i][8:0];
         end
         if (mdl_cnt == WIN - 1) begin
            for (int i = 0; i < 4; i++) begin
               r.lv[i*9 +: 9] = 9'(mdl_acc[i] / WIN);
               r.pk[i*9 +: 9] = 9'(mdl_pk[i]);
            end
            exp_q.push_back(r);
            mdl_zero();
            exp_v = 1'b1;
         end else begin
            mdl_cnt++;
         end
      end
      @(posedge clk_slow);
      #1;
      chk("win_count", 64'(win_count), 64'(mdl_cnt));
      chk("level_valid", 64'(level_valid), 64'(exp_v));
      if (level_valid) begin
         chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) pub = exp_q.pop_front();
      end
      chk("levels", 64'(lv_bus), 64'(pub.lv));
      chk("peaks", 64'(pk_bus), 64'(pub.pk));
   endtask

   task automatic idle();
      step(1'b0, 1'b0, band0_in, band1_in, band2_in, band3_in);
   endtask

   initial begin
      #2;
      chk("rst_levels", 64'(lv_bus), 64'd0);
      chk("rst_peaks", 64'(pk_bus), 64'd0);
      chk("rst_valid", 64'(level_valid), 64'd0);
      chk("rst_count", 64'(win_count), 64'd0);
      @(negedge clk_slow);
      rst = 1'b1;

      // 1: basic mean/peak, win_count 1,2,3,0 and single-cycle strobe
      step(1, 0, 10'd10, 0, 0, 0);
      step(1, 0, 10'd20, 0, 0, 0);
      step(1, 0, 10'd30, 0, 0, 0);
      step(1, 0, 10'd40, 0, 0, 0);
      chk("t1_level0", 64'(level0), 64'd25);
      chk("t1_peak0", 64'(peak0), 64'd40);
      idle();

      // 2: sign bit ignored, negative zero is zero
      step(1, 0, 0, 10'b1000000101, 0, 0);
      step(1, 0, 0, 10'b0000000011, 0, 0);
      step(1, 0, 0, 10'b1000000000, 0, 0);
      step(1, 0, 0, 10'b1000001000, 0, 0);
      chk("t2_level1", 64'(level1), 64'd4);
      chk("t2_peak1", 64'(peak1), 64'd8);

      // 3: full scale then zero
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 10'h3FF, 0);
      chk("t3_level2_fs", 64'(level2), 64'd511);
      chk("t3_peak2_fs", 64'(peak2), 64'd511);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
      chk("t3_level2_zero", 64'(level2), 64'd0);
      chk("t3_peak2_zero", 64'(peak2), 64'd0);

      // 4: gapped sampling, outputs hold across idle edges
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 0, 10'd7);
         if (i < 3) repeat (3) idle();
      end
      chk("t4_level3", 64'(level3), 64'd7);
      idle();

      // 5: clear beats a closing sample_en
      step(1, 0, 10'd10, 0, 0, 0);
      step(1, 0, 10'd20, 0, 0, 0);
      step(1, 0, 10'd30, 0, 0, 0);
      step(1, 0, 10'd40, 0, 0, 0);
      chk("t5_pre_level0", 64'(level0), 64'd25);
      for (int i = 0; i < 3; i++) step(1, 0, 10'd100, 0, 0, 0);
      step(1, 1, 10'd100, 0, 0, 0);
      chk("t5_clear_valid", 64'(level_valid), 64'd0);
      chk("t5_clear_level0", 64'(level0), 64'd25);
      for (int i = 0; i < 4; i++) step(1, 0, 10'd2, 0, 0, 0);
      chk("t5_level0", 64'(level0), 64'd2);
      chk("t5_peak0", 64'(peak0), 64'd2);

      // 6: asynchronous reset between edges
      step(1, 0, 10'd50, 10'd50, 10'd50, 10'd50);
      step(1, 0, 10'd50, 10'd50, 10'd50, 10'd50);
      #2;
      rst = 1'b0;
      sample_en = 1'b0;
      #1;
      chk("t6_async_levels", 64'(lv_bus), 64'd0);
      chk("t6_async_peaks", 64'(pk_bus), 64'd0);
      chk("t6_async_count", 64'(win_count), 64'd0);
      chk("t6_async_valid", 64'(level_valid), 64'd0);
      mdl_zero();
      exp_q.delete();
      pub = '0;
      @(negedge clk_slow);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) step(1, 0, 10'd4, 10'd4, 10'd4, 10'd4);
      chk("t6_level0", 64'(level0), 64'd4);
      chk("t6_level3", 64'(level3), 64'd4);
      idle();

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/fir_band_envelope.md
Name: fir_band_envelope

Overview:
- Sits directly downstream of the four 10-bit fixed-point FIR band filters and consumes their `fir_out` words on the slow sample clock.
- For each band, it measures the mean absolute level and the peak magnitude over a fixed window of 2^LOG2_WIN samples.
- It publishes all four results together, with a one-cycle valid strobe, for the gain/display logic that follows.
- Inputs use the sign-magnitude format the filter bank already uses: bit 9 is the sign, bits 8:0 are the magnitude.

Parameters:
- LOG2_WIN, 4: log2 of the window length in accepted samples. Legal range is 1..8.
- NBANDS, 4: number of bands. Fixed at 4; the ports are written out explicitly.

Ports:
- clk_slow, input, 1: sample-rate clock, the same clock that drives the filter bank.
- rst, input, 1: asynchronous, active-low reset.
- sample_en, input, 1: a sample is accepted on any rising edge where this is high.
- clear, input, 1: synchronous restart of the current window.
- band0_in, input, 10: band 0 FIR output, sign-magnitude.
- band1_in, input, 10: band 1 FIR output, sign-magnitude.
- band2_in, input, 10: band 2 FIR output, sign-magnitude.
- band3_in, input, 10: band 3 FIR output, sign-magnitude.
- level0 .. level3, output, 9 each: mean magnitude of the last completed window.
- peak0 .. peak3, output, 9 each: maximum magnitude seen in the last completed window.
- level_valid, output, 1: one-cycle pulse when new results are published.
- win_count, output, LOG2_WIN: number of samples accepted so far in the current window.

Behaviour:
- Reset (rst low, asynchronous): every levelN, peakN, accumulator, running peak, win_count and level_valid goes to 0. On release, the first window starts empty.
- Magnitude: mag = in[8:0]. The sign bit is ignored. Negative zero (10'b1000000000) has magnitude 0.
- Accumulators: one per band, width 9+LOG2_WIN bits. Overflow is impossible by construction, so there is no saturation logic.
- Running peak: one 9-bit register per band.
- Accept edge (sample_en=1, clear=0):
  - accN <= accN + magN.
  - pkN <= max(pkN, magN).
  - win_count increments.
- Window close: the accept edge where win_count == 2^LOG2_WIN - 1 closes the window. On that same edge:
  - levelN <= (accN + magN) >> LOG2_WIN, i.e. truncate, no rounding.
  - peakN <= max(pkN, magN).
  - accN <= 0, pkN <= 0, win_count <= 0 (wrap-around).
  - level_valid <= 1.
- level_valid timing: high for exactly the one cycle after the closing edge, independent of whether sample_en is high in that cycle.
- Latency: levelN and peakN change only at the closing edge. They hold their values until the next closing edge or reset.
- Windows are back-to-back. The sample accepted on the edge after a close is sample 0 of the new window, so no sample is dropped.
- Edges with sample_en=0: no state change, except that level_valid returns to 0.
- clear=1 on any edge:
  - accN, pkN and win_count go to 0.
  - A simultaneous sample_en is discarded; clear has priority.
  - levelN and peakN keep their last published values.
  - level_valid is 0 in the next cycle, even if that edge would otherwise have closed the window.
- Reset mid-window: all partial accumulation is lost and the outputs return to 0.
- Datapath: registered outputs only; no combinational path from inputs to outputs.
- State: the only state is win_count; the window runs as ACCUM with its final sample acting as CLOSE. No separate FSM register is required.

Test Plan (all scenarios use LOG2_WIN=2, i.e. 4-sample windows):
1. Basic mean and peak:
   - Stimulus: band0 = 10, 20, 30, 40 (positive), 4 consecutive sample_en.
   - Required: level0=25, peak0=40. level_valid high for exactly one cycle after the 4th accept edge. win_count sequence 1, 2, 3, 0.
2. Sign handling:
   - Stimulus: band1 = 10'b1000000101 (-5), 10'b0000000011 (+3), 10'b1000000000 (-0), 10'b1000001000 (-8).
   - Required: level1=(5+3+0+8)>>2=4, peak1=8.
3. Full scale:
   - Stimulus: band2 = 10'b1111111111 for 4 samples.
   - Required: level2=511, peak2=511, no wrap. Then band2 = 0 for 4 samples; required: level2=0, peak2=0.
4. Gapped sampling:
   - Stimulus: band3 = 7 for 4 accepted samples, with sample_en low for 3 cycles between each.
   - Required: level3=7. level_valid fires once, only after the 4th accept. Outputs unchanged during the gaps.
5. Clear priority:
   - Stimulus: after a published level0=25, accept 3 samples of 100. Assert clear together with sample_en on the 4th. Then accept 4 samples of 2.
   - Required: no level_valid at the clear. level0 stays 25 until the new window closes, then level0=2, peak0=2.
6. Asynchronous reset:
   - Stimulus: assert rst low mid-window between clock edges.
   - Required: all level/peak outputs and win_count read 0 immediately, without waiting for a clock edge. After release, a window of 4, 4, 4, 4 gives level=4.
